subleq_core_hs: RTL and testbench



---
 rtl/subleq_core_hs_if.sv | 16 +
 rtl/subleq_core_hs.sv | 120 ++++++++++++
 tb/tb_subleq_core_hs.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subleq_core_hs_if.sv
// subleq_core_hs_if: req/ack memory bus for the SUBLEQ core.
// Separate read and write data; a transfer completes on a clock edge with req & ack.
interface subleq_core_hs_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/subleq_core_hs.sv
// subleq_core_hs: parametrised SUBLEQ core, mem[A] <- mem[A] - mem[B], branch to C if <= 0.
// One bus transfer per state; a state advances only on its ack.
module subleq_core_hs #(
    parameter int                XLEN       = 32,
    parameter int                ADDR_W     = 32,
    parameter bit                BIG_ENDIAN = 1,
    parameter bit                HALT_EN    = 1,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    subleq_core_hs_if.master    mem,
    output logic                halted,
    output logic [31:0]         instret,
    output logic [ADDR_W-1:0]   dbg_pc
);
    localparam int BYTES = XLEN / 8;
    localparam logic [ADDR_W-1:0] STEP1 = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(2 * BYTES);
    localparam logic [ADDR_W-1:0] STEP3 = ADDR_W'(3 * BYTES);

    typedef enum logic [2:0] {IDLE, F_A, F_B, F_C, L_A, L_B, WR, HALT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, a, b, c;
    logic [XLEN-1:0]   op_a, op_b, rdata, r;
    logic              done, taken;

    // Bus byte order conversion; the same swap serves read and write.
    function automatic logic [XLEN-1:0] order(input logic [XLEN-1:0] w);
        logic [XLEN-1:0] s;
        for (int i = 0; i < BYTES; i++) s[8*i +: 8] = w[8*(BYTES-1-i) +: 8];
        return BIG_ENDIAN ? s : w;
    endfunction

    assign rdata  = order(mem.rdata);
    assign r      = op_a - op_b;
    assign taken  = r[XLEN-1] | ~|r;
    assign done   = mem.req & mem.ack;
    assign halted = state == HALT;
    assign dbg_pc = pc;

    always_comb begin
        state_nx  = state;
        mem.req   = 1'b0;
        mem.we    = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        case (state)
            IDLE: state_nx = cpu_en ? F_A : IDLE;
            F_A: begin
                mem.req  = 1'b1;
                mem.addr = pc;
                state_nx = mem.ack ? F_B : F_A;
            end
            F_B: begin
                mem.req  = 1'b1;
                mem.addr = pc + STEP1;
                state_nx = mem.ack ? F_C : F_B;
            end
            F_C: begin
                mem.req  = 1'b1;
                mem.addr = pc + STEP2;
                state_nx = mem.ack ? L_A : F_C;
            end
            L_A: begin
                mem.req  = 1'b1;
                mem.addr = a;
                state_nx = mem.ack ? L_B : L_A;
            end
            L_B: begin
                mem.req  = 1'b1;
                mem.addr = b;
                state_nx = mem.ack ? WR : L_B;
            end
            WR: begin
                mem.req   = 1'b1;
                mem.we    = 1'b1;
                mem.addr  = a;
                mem.wdata = order(r);
                // A taken branch to the all-ones address is the halt idiom.
                state_nx  = !mem.ack ? WR :
                            (HALT_EN && taken && &c) ? HALT :
                            cpu_en ? F_A : IDLE;
            end
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            op_a    <= '0;
            op_b    <= '0;
            instret <= '0;
        end else begin
            state <= state_nx;
            if (done) begin
                case (state)
                    F_A: a <= ADDR_W'(rdata);
                    F_B: b <= ADDR_W'(rdata);
                    F_C: c <= ADDR_W'(rdata);
                    L_A: op_a <= rdata;
                    L_B: op_b <= rdata;
                    WR: begin
                        pc      <= taken ? c : pc + STEP3;
                        instret <= instret + 32'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_subleq_core_hs.sv
// tb_subleq_core_hs: directed checks of the SUBLEQ core against hand-computed results.
// u0 runs default parameters on a big-endian byte memory; u1 is the 16-bit little-endian variant.
module tb_subleq_core_hs;
    logic        clk = 0;
    logic        rst0 = 0, en0 = 0, rst1 = 0, en1 = 0;
    logic        halted0, halted1;
    logic [31:0] instret0, instret1;
    logic [31:0] pc0;
    logic [11:0] pc1;
    int          checks = 0, errors = 0;
    bit          rnd = 0;
    int          dly0 = 0;
    int          unstable = 0;
    logic        pend = 0, sw;
    logic [31:0] sa, sd;
    logic [7:0]  m0 [0:4095];
    logic [7:0]  m1 [0:4095];
    logic [31:0] d [5];
    logic [31:0] snap [5];

    always #5 clk = ~clk;

    subleq_core_hs_if #(.XLEN(32), .ADDR_W(32)) bus0 ();
    subleq_core_hs_if #(.XLEN(16), .ADDR_W(12)) bus1 ();

    subleq_core_hs u0 (.clk(clk), .rst(rst0), .cpu_en(en0), .mem(bus0),
                       .halted(halted0), .instret(instret0), .dbg_pc(pc0));
    subleq_core_hs #(.XLEN(16), .ADDR_W(12), .BIG_ENDIAN(0)) u1 (
        .clk(clk), .rst(rst1), .cpu_en(en1), .mem(bus1),
        .halted(halted1), .instret(instret1), .dbg_pc(pc1));

    // Bus lane i carries the byte at addr+i.
    always_comb begin
        bus0.rdata = '0;
        for (int i = 0; i < 4; i++) bus0.rdata[8*i +: 8] = m0[bus0.addr[11:0] + 12'(i)];
    end
    assign bus0.ack   = rnd ? (dly0 == 0) : 1'b1;
    assign bus1.rdata = {m1[bus1.addr + 12'd1], m1[bus1.addr]};
    assign bus1.ack   = 1'b1;

    always @(posedge clk) begin
        if (bus0.req && bus0.ack) begin
            if (bus0.we)
                for (int i = 0; i < 4; i++) m0[bus0.addr[11:0] + 12'(i)] <= bus0.wdata[8*i +: 8];
            dly0 <= int'($urandom_range(0, 5));
        end else if (bus0.req && dly0 > 0) begin
            dly0 <= dly0 - 1;
        end
        if (bus1.req && bus1.ack && bus1.we) begin
            m1[bus1.addr]         <= bus1.wdata[7:0];
            m1[bus1.addr + 12'd1] <= bus1.wdata[15:8];
        end
    end

    // Request payload must hold while a transfer waits for ack.
    always @(posedge clk) begin
        if (pend && rst0 && (bus0.addr !== sa || bus0.we !== sw || bus0.wdata !== sd))
            unstable <= unstable + 1;
        pend <= rst0 && bus0.req && !bus0.ack;
        sa   <= bus0.addr;
        sw   <= bus0.we;
        sd   <= bus0.wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic w0(input logic [31:0] a, input logic [31:0] v);
        m0[a[11:0]]         <= v[31:24];
        m0[a[11:0] + 12'd1] <= v[23:16];
        m0[a[11:0] + 12'd2] <= v[15:8];
        m0[a[11:0] + 12'd3] <= v[7:0];
    endtask

    function automatic logic [31:0] r0(input logic [31:0] a);
        return {m0[a[11:0]], m0[a[11:0] + 12'd1], m0[a[11:0] + 12'd2], m0[a[11:0] + 12'd3]};
    endfunction

    task automatic ins0(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        w0(p, a);
        w0(p + 4, b);
        w0(p + 8, c);
    endtask

    task automatic clr0();
        for (int i = 0; i < 4096; i++) m0[i] <= 8'h00;
    endtask

    task automatic reset0();
        en0  = 0;
        rst0 = 0;
        repeat (2) @(negedge clk);
        clr0();
    endtask

    task automatic go0(input logic en);
        en0  = en;
        rst0 = 1;
    endtask

    task automatic wait_ret0(input int n, input string tag);
        int c = 0;
        while (instret0 < 32'(n) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(instret0 >= 32'(n)), 1);
    endtask

    task automatic wait_halt0(input string tag);
        int c = 0;
        while (!halted0 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(halted0), 1);
    endtask

    task automatic one_instr(input logic [31:0] x, input logic [31:0] y);
        reset0();
        ins0(0, 32'h100, 32'h104, 32'h40);
        w0(32'h100, x);
        w0(32'h104, y);
        go0(1);
        @(negedge clk);
        en0 = 0;
        wait_ret0(1, "t2_timeout");
    endtask

    task automatic load_prog();
        clr0();
        for (int i = 0; i < 20; i++)
            ins0(32'(12 * i), 32'h400 + 32'(4 * (i % 5)), 32'h400 + 32'(4 * ((3 * i + 1) % 5)),
                 32'(12 * (i + 1)));
        ins0(32'd240, 32'h500, 32'h500, 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) w0(32'h400 + 32'(4 * k), 32'(k * 1000 - 1500));
    endtask

    initial begin
        // 1: basic instruction, zero-wait timing
        reset0();
        ins0(0, 32'h100, 32'h104, 32'h40);
        w0(32'h100, 5);
        w0(32'h104, 3);
        go0(1);
        @(negedge clk);
        chk("t1_first_req", 64'(bus0.req), 1);
        chk("t1_first_addr", 64'(bus0.addr), 0);
        chk("t1_first_we", 64'(bus0.we), 0);
        repeat (5) @(negedge clk);
        chk("t1_wr_we", 64'(bus0.we), 1);
        chk("t1_wr_addr", 64'(bus0.addr), 64'h100);
        chk("t1_wr_data", 64'(bus0.wdata), 64'h0200_0000);
        chk("t1_instret_pre", 64'(instret0), 0);
        en0 = 0;
        @(negedge clk);
        chk("t1_instret", 64'(instret0), 1);
        chk("t1_pc", 64'(pc0), 12);
        chk("t1_mem", 64'(r0(32'h100)), 2);
        chk("t1_idle_req", 64'(bus0.req), 0);

        // 2: equal operands and negative result
        one_instr(3, 3);
        chk("t2_eq_mem", 64'(r0(32'h100)), 0);
        chk("t2_eq_pc", 64'(pc0), 64'h40);
        one_instr(3, 5);
        chk("t2_neg_mem", 64'(r0(32'h100)), 64'hFFFF_FFFE);
        chk("t2_neg_pc", 64'(pc0), 64'h40);

        // 3: halt, then ignore cpu_en
        reset0();
        ins0(0, 32'h100, 32'h100, 32'hFFFF_FFFF);
        w0(32'h100, 7);
        go0(1);
        wait_halt0("t3_halt_timeout");
        chk("t3_mem", 64'(r0(32'h100)), 0);
        chk("t3_instret", 64'(instret0), 1);
        begin
            int cnt = 0;
            for (int i = 0; i < 100; i++) begin
                en0 = ~en0;
                @(negedge clk);
                cnt += int'(bus0.req);
            end
            chk("t3_req_cycles", 64'(cnt), 0);
            chk("t3_halted", 64'(halted0), 1);
        end

        // 4: 20-instruction program, zero-wait vs random wait states
        for (int k = 0; k < 5; k++) d[k] = 32'(k * 1000 - 1500);
        for (int i = 0; i < 20; i++) d[i % 5] = d[i % 5] - d[(3 * i + 1) % 5];
        reset0();
        load_prog();
        rnd = 0;
        go0(1);
        wait_halt0("t4_zw_timeout");
        for (int k = 0; k < 5; k++) begin
            snap[k] = r0(32'h400 + 32'(4 * k));
            chk("t4_model", 64'(snap[k]), 64'(d[k]));
        end
        chk("t4_zw_instret", 64'(instret0), 21);
        reset0();
        load_prog();
        rnd = 1;
        go0(1);
        wait_halt0("t4_rnd_timeout");
        for (int k = 0; k < 5; k++) chk("t4_rnd_mem", 64'(r0(32'h400 + 32'(4 * k))), 64'(snap[k]));
        chk("t4_rnd_instret", 64'(instret0), 21);
        chk("t4_stable", 64'(unstable), 0);
        rnd = 0;

        // 5a: cpu_en dropped in L_A
        reset0();
        ins0(0, 32'h100, 32'h104, 32'h40);
        w0(32'h100, 9);
        w0(32'h104, 4);
        go0(1);
        repeat (4) @(negedge clk);
        chk("t5_la_addr", 64'(bus0.addr), 64'h100);
        en0 = 0;
        wait_ret0(1, "t5_timeout");
        chk("t5_mem", 64'(r0(32'h100)), 5);
        chk("t5_idle_req", 64'(bus0.req), 0);
        repeat (5) @(negedge clk);
        chk("t5_idle_hold", 64'(bus0.req), 0);
        chk("t5_instret", 64'(instret0), 1);

        // 5b: reset asserted during F_C
        reset0();
        ins0(0, 32'h100, 32'h104, 32'h40);
        ins0(32'h40, 32'h100, 32'h104, 32'h80);
        w0(32'h100, 1);
        w0(32'h104, 1);
        go0(1);
        wait_ret0(1, "t5b_timeout");
        chk("t5b_pc", 64'(pc0), 64'h40);
        begin
            int c = 0;
            while (!(bus0.req && bus0.addr == 32'h48) && c < 20) begin
                @(negedge clk);
                c++;
            end
            chk("t5b_fc_seen", 64'(bus0.addr), 64'h48);
        end
        #1 rst0 = 0;
        #1;
        chk("t5b_req_async", 64'(bus0.req), 0);
        chk("t5b_pc_async", 64'(pc0), 0);
        chk("t5b_instret", 64'(instret0), 0);
        @(negedge clk);
        en0  = 0;
        rst0 = 1;
        @(negedge clk);
        chk("t5b_pc_after", 64'(pc0), 0);
        chk("t5b_req_after", 64'(bus0.req), 0);

        // 6: 16-bit little-endian variant, wrap and address truncation
        for (int i = 0; i < 4096; i++) m1[i] <= 8'h00;
        @(negedge clk);
        {m1[1], m1[0]} = 16'hF123;
        {m1[3], m1[2]} = 16'h0200;
        {m1[5], m1[4]} = 16'h0040;
        {m1[12'h124], m1[12'h123]} = 16'h8000;
        {m1[12'h201], m1[12'h200]} = 16'h0001;
        en1  = 1;
        rst1 = 1;
        @(negedge clk);
        en1 = 0;
        begin
            int c = 0;
            while (instret1 == 0 && c < 50) begin
                @(negedge clk);
                c++;
            end
        end
        chk("t6_instret", 64'(instret1), 1);
        chk("t6_pc", 64'(pc1), 6);
        chk("t6_mem", 64'({m1[12'h124], m1[12'h123]}), 64'h7FFF);
        chk("t6_halted", 64'(halted1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
